regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the picoMIPS general-purpose register file.
- NREG registers of n bits; two combinational read ports (Rd, Rs); a primary write port for single-cycle ALU results; a secondary late-writeback port for multi-cycle units such as the multiplier.
- Per-register busy scoreboard so the decoder can stall on pending results.
- Optional hardwired-zero R0 and optional write-to-read bypass.

Parameters:
- n, 8, data bus width.
- NREG, 4, number of registers; power of two, 2 to 32.
- ZERO_R0, 0, if 1 register 0 always reads 0, ignores writes, never goes busy.
- BYPASS, 0, if 1 a read of a register being written this cycle returns the incoming write data.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- w  in  1  primary write enable.
- Wdata  in  n  primary write data.
- Rdno  in  AW  destination/first read register number; AW = $clog2(NREG).
- Rsno  in  AW  second read register number.
- Rd  out  n  contents of gpr[Rdno].
- Rs  out  n  contents of gpr[Rsno].
- rsv  in  1  reserve: mark register Rsvno busy (multi-cycle op issued).
- Rsvno  in  AW  register to reserve.
- w2  in  1  late writeback enable.
- W2no  in  AW  late writeback register number.
- W2data  in  n  late writeback data.
- Rd_busy  out  1  busy[Rdno].
- Rs_busy  out  1  busy[Rsno].
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset: on a posedge with reset=1, all gpr ← 0 and all busy ← 0. Reset overrides every write and reserve in that cycle. Outputs then read 0, busy flags 0, any_busy 0.
- Reads: combinational from Rdno/Rsno. With BYPASS=0 a write becomes visible the cycle after the edge.
- BYPASS=1:
  - If w and Rdno/Rsno matches the write target, the output is Wdata.
  - Otherwise, if w2, busy[W2no]=1 and the index matches W2no, the output is W2data.
  - The primary write target is Rdno, so Rd bypasses on w. Rs bypasses only when Rsno==Rdno.
  - Busy outputs are never bypassed.
- Primary write: on posedge with w=1, gpr[Rdno] ← Wdata and busy[Rdno] ← 0. This resolves WAW: the newer result wins and cancels the pending one.
- Late write: on posedge with w2=1 and busy[W2no]=1, gpr[W2no] ← W2data and busy[W2no] ← 0. If busy[W2no]=0 the write is squashed and gpr is unchanged.
- Reserve: on posedge with rsv=1, busy[Rsvno] ← 1.
- Same-cycle priority per register:
  - Data: w beats w2.
  - Busy: rsv set beats any clear. A register reserved and written in the same cycle ends busy, with the data written.
- If w and w2 target the same register, gpr takes Wdata, busy clears, and the w2 data is discarded. This holds unless rsv also targets that register, in which case busy stays 1 per the rule above.
- ZERO_R0=1: writes and reserves to index 0 are ignored; Rd/Rs for index 0 read 0; busy[0] is constant 0.
- any_busy is registered-state derived: combinational OR of the busy vector, no extra latency.
- Latency: write-to-read is 1 cycle (0 with BYPASS); reserve-to-busy-visible is 1 cycle; w2-to-busy-clear is 1 cycle.
- Out-of-range indices cannot occur (NREG is a power of two).

Decomposition:
- Package regfile_pkg: function clog2-based AW helper, localparam defaults for n and NREG, typedef for the busy vector type.
- One sub-module, regfile_scoreboard: busy vector with rsv/w/w2 set/clear logic, busy outputs and any_busy.
- Data array, writes and bypass muxing stay in the top module.

Test Plan:
- Reset then read: reset=1 for 1 cycle with w=1, Rdno=2, Wdata=8'hAA → after release Rd=0 for every Rdno, any_busy=0.
- Basic write/read: w=1, Rdno=1, Wdata=8'h5C → next cycle Rdno=1 gives Rd=8'h5C. Rsno=1 gives Rs=8'h5C. BYPASS=1: Rd=8'h5C in the same cycle.
- Scoreboard: rsv=1, Rsvno=3 → next cycle Rd_busy=1 for Rdno=3, any_busy=1. Then w2=1, W2no=3, W2data=8'h21 → next cycle busy 0, Rd=8'h21.
- WAW squash: reserve r2; primary w to r2 with 8'h11; later w2 to r2 with 8'h99 → r2 reads 8'h11, busy 0.
- Collision: same cycle w to r1 8'h0F, w2 to r1 (busy) 8'hF0, rsv r1 → r1=8'h0F, busy[1]=1.
- ZERO_R0=1: w to r0 8'hFF, rsv r0 → Rd=0, Rd_busy=0, any_busy=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared helpers and types for the scoreboarded register file.
package regfile_pkg;

  localparam int N_DEF    = 8;
  localparam int NREG_DEF = 4;
  localparam int NREG_MAX = 32;

  typedef logic [NREG_MAX-1:0] busy_vec_t;

  function automatic int addr_width(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  // Registers that can ever hold a busy bit: in range and not a hardwired R0.
  function automatic busy_vec_t trackable_mask(input int nreg, input bit zero_r0);
    busy_vec_t m;
    m = '0;
    for (int i = 0; i < NREG_MAX; i++) begin
      m[i] = (i < nreg) && !(zero_r0 && (i == 0));
    end
    return m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: reserve sets, primary or accepted late write clears.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int ZERO_R0 = 0,
  localparam int AW     = addr_width(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w,
  input  logic [AW-1:0] Rdno,
  input  logic [AW-1:0] Rsno,
  input  logic          rsv,
  input  logic [AW-1:0] Rsvno,
  input  logic          w2,
  input  logic [AW-1:0] W2no,
  output logic          Rd_busy,
  output logic          Rs_busy,
  output logic          any_busy,
  output logic          w2_ok
);

  localparam busy_vec_t       MASK_FULL = trackable_mask(NREG, ZERO_R0 != 0);
  localparam logic [NREG-1:0] MASK      = MASK_FULL[NREG-1:0];

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // A late write only lands on a register still waiting for it.
  assign w2_ok = w2 && busy_q[W2no];

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (w2_ok) busy_d[W2no]  = 1'b0;
    if (w)     busy_d[Rdno]  = 1'b0;
    if (rsv)   busy_d[Rsvno] = 1'b1;
    busy_d = busy_d & MASK;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign Rd_busy  = busy_q[Rdno];
  assign Rs_busy  = busy_q[Rsno];
  assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with two read ports, primary and late write ports,
// busy scoreboard, optional hardwired-zero R0 and optional write-to-read bypass.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int n       = N_DEF,
  parameter int NREG    = NREG_DEF,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 0,
  localparam int AW     = addr_width(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          w,
  input  logic [n-1:0]  Wdata,
  input  logic [AW-1:0] Rdno,
  input  logic [AW-1:0] Rsno,
  output logic [n-1:0]  Rd,
  output logic [n-1:0]  Rs,
  input  logic          rsv,
  input  logic [AW-1:0] Rsvno,
  input  logic          w2,
  input  logic [AW-1:0] W2no,
  input  logic [n-1:0]  W2data,
  output logic          Rd_busy,
  output logic          Rs_busy,
  output logic          any_busy
);

  logic [n-1:0] gpr_q [NREG];
  logic [n-1:0] gpr_d [NREG];
  logic         w2_ok;
  logic         wr_live;

  regfile_scoreboard #(
    .NREG    (NREG),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .w        (w),
    .Rdno     (Rdno),
    .Rsno     (Rsno),
    .rsv      (rsv),
    .Rsvno    (Rsvno),
    .w2       (w2),
    .W2no     (W2no),
    .Rd_busy  (Rd_busy),
    .Rs_busy  (Rs_busy),
    .any_busy (any_busy),
    .w2_ok    (w2_ok)
  );

  // A primary write to a hardwired R0 is dropped entirely.
  assign wr_live = w && !((ZERO_R0 != 0) && (Rdno == '0));

  always_comb begin
    gpr_d = gpr_q;
    if (w2_ok)   gpr_d[W2no] = W2data;
    if (wr_live) gpr_d[Rdno] = Wdata;
  end

  // NOTE: the array is reset because software may read any register straight after reset and expect 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else begin
      gpr_q <= gpr_d;
    end
  end

  // Primary write bypass wins over late write bypass, matching write priority.
  always_comb begin
    Rd = gpr_q[Rdno];
    Rs = gpr_q[Rsno];
    if (BYPASS != 0) begin
      if (wr_live)                     Rd = Wdata;
      else if (w2_ok && W2no == Rdno)  Rd = W2data;
      if (wr_live && Rsno == Rdno)     Rs = Wdata;
      else if (w2_ok && W2no == Rsno)  Rs = W2data;
    end
    if ((ZERO_R0 != 0) && Rdno == '0) Rd = '0;
    if ((ZERO_R0 != 0) && Rsno == '0) Rs = '0;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default and (ZERO_R0=1, BYPASS=1) instances share stimulus.
module tb_regfile_sb;

  logic       clk;
  logic       reset;
  logic       w, rsv, w2;
  logic [7:0] wdata, w2data;
  logic [1:0] rdno, rsno, rsvno, w2no;

  logic [7:0] rd0, rs0, rd1, rs1;
  logic       rdb0, rsb0, any0, rdb1, rsb1, any1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state per instance: 0 = plain, 1 = zero-R0 with bypass.
  logic [7:0] m_mem  [2][4];
  bit         m_busy [2][4];

  regfile_sb #(.n(8), .NREG(4), .ZERO_R0(0), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .w(w), .Wdata(wdata), .Rdno(rdno), .Rsno(rsno),
    .Rd(rd0), .Rs(rs0), .rsv(rsv), .Rsvno(rsvno), .w2(w2), .W2no(w2no),
    .W2data(w2data), .Rd_busy(rdb0), .Rs_busy(rsb0), .any_busy(any0)
  );

  regfile_sb #(.n(8), .NREG(4), .ZERO_R0(1), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .w(w), .Wdata(wdata), .Rdno(rdno), .Rsno(rsno),
    .Rd(rd1), .Rs(rs1), .rsv(rsv), .Rsvno(rsvno), .w2(w2), .W2no(w2no),
    .W2data(w2data), .Rd_busy(rdb1), .Rs_busy(rsb1), .any_busy(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst, w;
    logic [7:0] wdata;
    logic [1:0] rdno, rsno;
    logic       rsv;
    logic [1:0] rsvno;
    logic       w2;
    logic [1:0] w2no;
    logic [7:0] w2data;
    logic [7:0] e_rd, e_rs;
    logic       e_rdb, e_any;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; w = v.w; wdata = v.wdata; rdno = v.rdno; rsno = v.rsno;
    rsv = v.rsv; rsvno = v.rsvno; w2 = v.w2; w2no = v.w2no; w2data = v.w2data;
  endtask

  task automatic idle(input logic [1:0] rd_i, input logic [1:0] rs_i);
    reset = 0; w = 0; wdata = 0; rdno = rd_i; rsno = rs_i;
    rsv = 0; rsvno = 0; w2 = 0; w2no = 0; w2data = 0;
  endtask

  // Register contents seen by a read port, from the stated visibility rules.
  function automatic logic [7:0] m_read(input int k, input logic [1:0] idx);
    if (k == 1 && idx == 2'd0) return 8'h00;
    if (k == 1) begin
      if (w && idx == rdno) return wdata;
      if (w2 && m_busy[k][w2no] && idx == w2no) return w2data;
    end
    return m_mem[k][idx];
  endfunction

  function automatic bit m_any(input int k);
    return m_busy[k][0] | m_busy[k][1] | m_busy[k][2] | m_busy[k][3];
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int r = 0; r < 4; r++) begin
          m_mem[k][r] = 8'h00;
          m_busy[k][r] = 1'b0;
        end
      end else begin
        bit late;
        late = w2 && m_busy[k][w2no];
        if (late) begin
          m_mem[k][w2no] = w2data;
          m_busy[k][w2no] = 1'b0;
        end
        if (w && !(k == 1 && rdno == 2'd0)) begin
          m_mem[k][rdno] = wdata;
          m_busy[k][rdno] = 1'b0;
        end
        if (rsv && !(k == 1 && rsvno == 2'd0)) m_busy[k][rsvno] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, " m0.Rd"},  rd0,  m_read(0, rdno));
    check({tag, " m0.Rs"},  rs0,  m_read(0, rsno));
    check({tag, " m0.Rdb"}, rdb0, m_busy[0][rdno]);
    check({tag, " m0.Rsb"}, rsb0, m_busy[0][rsno]);
    check({tag, " m0.any"}, any0, m_any(0));
    check({tag, " m1.Rd"},  rd1,  m_read(1, rdno));
    check({tag, " m1.Rs"},  rs1,  m_read(1, rsno));
    check({tag, " m1.Rdb"}, rdb1, m_busy[1][rdno]);
    check({tag, " m1.Rsb"}, rsb1, m_busy[1][rsno]);
    check({tag, " m1.any"}, any1, m_any(1));
  endtask

  initial begin
    idle(0, 0);
    @(posedge clk); #1;

    // Reset overrides a simultaneous write and reserve.
    reset = 1; w = 1; rdno = 2; wdata = 8'hAA; rsv = 1; rsvno = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      idle(2'(i), 2'(i));
      @(negedge clk);
      check($sformatf("reset rd0[%0d]", i), rd0, 8'h00);
      check($sformatf("reset rd1[%0d]", i), rd1, 8'h00);
      check("reset any0", any0, 1'b0);
      check("reset any1", any1, 1'b0);
      check_model("reset");
      tick();
    end

    //          rst w  wdata  rd rs rsv rsvn w2 w2n w2data  e_rd   e_rs  rdb any
    tbl.push_back('{0, 1, 8'h5C, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 1, 3, 0, 0, 8'h00, 8'h5C, 8'h5C, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 3, 1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h5C, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 3, 3, 0, 0, 1, 3, 8'h21, 8'h00, 8'h00, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 3, 1, 0, 0, 0, 0, 8'h00, 8'h21, 8'h5C, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 2, 3, 1, 2, 0, 0, 8'h00, 8'h00, 8'h21, 0, 0});
    tbl.push_back('{0, 1, 8'h11, 2, 2, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 2, 2, 0, 0, 1, 2, 8'h99, 8'h11, 8'h11, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 2, 1, 0, 0, 0, 0, 8'h00, 8'h11, 8'h5C, 0, 0});
    tbl.push_back('{0, 0, 8'h00, 1, 2, 1, 1, 0, 0, 8'h00, 8'h5C, 8'h11, 0, 0});
    tbl.push_back('{0, 1, 8'h0F, 1, 1, 1, 1, 1, 1, 8'hF0, 8'h5C, 8'h5C, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h0F, 8'h0F, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 3, 0, 0, 1, 1, 8'h77, 8'h0F, 8'h21, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00, 8'h77, 8'h00, 0, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      check($sformatf("tbl[%0d] Rd", i),   rd0,  tbl[i].e_rd);
      check($sformatf("tbl[%0d] Rs", i),   rs0,  tbl[i].e_rs);
      check($sformatf("tbl[%0d] Rdb", i),  rdb0, tbl[i].e_rdb);
      check($sformatf("tbl[%0d] any", i),  any0, tbl[i].e_any);
      check_model($sformatf("tbl[%0d]", i));
      tick();
    end

    // Hardwired R0: write and reserve to index 0 are ignored on the zero-R0 instance.
    idle(0, 0); reset = 1;
    tick();
    idle(0, 0); w = 1; wdata = 8'hFF; rsv = 1; rsvno = 0;
    @(negedge clk);
    check("zr0 same-cycle Rd1", rd1, 8'h00);
    check_model("zr0 a");
    tick();
    idle(0, 0);
    @(negedge clk);
    check("zr0 Rd1", rd1, 8'h00);
    check("zr0 Rdb1", rdb1, 1'b0);
    check("zr0 any1", any1, 1'b0);
    check("plain r0 Rd0", rd0, 8'hFF);
    check("plain r0 Rdb0", rdb0, 1'b1);
    check_model("zr0 b");
    tick();

    // Same-cycle bypass of a primary write.
    idle(1, 1); w = 1; wdata = 8'h5C;
    @(negedge clk);
    check("bypass Rd1", rd1, 8'h5C);
    check("bypass Rs1", rs1, 8'h5C);
    check("no-bypass Rd0", rd0, 8'h00);
    check_model("bypass");
    tick();

    // Late-write bypass: reserve r2, then late write shows the data the same cycle.
    idle(2, 3); rsv = 1; rsvno = 2;
    @(negedge clk); check_model("lbyp a"); tick();
    idle(2, 2); w2 = 1; w2no = 2; w2data = 8'h3E;
    @(negedge clk);
    check("late bypass Rd1", rd1, 8'h3E);
    check("late no-bypass Rd0", rd0, 8'h00);
    check_model("lbyp b");
    tick();

    for (int c = 0; c < 1500; c++) begin
      reset  = ($urandom_range(0, 59) == 0);
      w      = ($urandom_range(0, 2) == 0);
      wdata  = 8'($urandom);
      rdno   = 2'($urandom);
      rsno   = ($urandom_range(0, 3) == 0) ? rdno : 2'($urandom);
      rsv    = ($urandom_range(0, 2) == 0);
      rsvno  = 2'($urandom);
      w2     = ($urandom_range(0, 1) == 0);
      w2no   = ($urandom_range(0, 3) == 0) ? rdno : 2'($urandom);
      w2data = 8'($urandom);
      @(negedge clk);
      if (!reset) check_model($sformatf("rand[%0d]", c));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
